// File: rtl/rt_ibex_hws_ctrl.sv
// rt_ibex_hws_ctrl
// Initiator-side controller for the RT-IBEX hardware stacking unit. Requests
// a context SAVE on interrupt entry and a RESTORE on mret, sequences the
// stacker start/done/ack handshake, halts fetch while a sequence runs, tracks
// the nesting depth, tail-chains mret+irq, and flags overflow and timeouts.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   irq_req_i        enabled interrupt pending (level)
//   mret_i           mret retiring (single-cycle pulse)
//   hws_start_o      start request to the stacker
//   hws_mode_o       SAVE or RESTORE
//   hws_done_i       registered done from the stacker
//   hws_ack_o        acknowledges done
//   irq_take_o       interrupt committed, redirect to handler
//   mret_done_o      mret restore complete, redirect to mepc
//   fetch_halt_o     halts IF/ID issue while a sequence runs
//   nest_level_o     current stacked-frame count
//   err_overflow_o   sticky: interrupt refused at full depth
//   err_timeout_o    sticky: stacker did not signal done in time

package rt_ibex_hws_pkg;
  typedef enum logic {
    HWS_SAVE    = 1'b0,
    HWS_RESTORE = 1'b1
  } hw_stacking_mode_t;
endpackage

module rt_ibex_hws_ctrl
  import rt_ibex_hws_pkg::*;
#(
  parameter int unsigned NEST_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              irq_req_i,
  input  logic                              mret_i,
  output logic                              hws_start_o,
  output hw_stacking_mode_t                 hws_mode_o,
  input  logic                              hws_done_i,
  output logic                              hws_ack_o,
  output logic                              irq_take_o,
  output logic                              mret_done_o,
  output logic                              fetch_halt_o,
  output logic [$clog2(NEST_DEPTH+1)-1:0]   nest_level_o,
  output logic                              err_overflow_o,
  output logic                              err_timeout_o
);

  localparam int unsigned NW = $clog2(NEST_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [NW-1:0] NEST_MAX = NW'(NEST_DEPTH);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE,
    SAVE_START,
    SAVE_WAIT,
    SAVE_ACK,
    RST_START,
    RST_WAIT,
    RST_ACK,
    TAIL,
    PASS,
    ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [NW-1:0]     nest_q, nest_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              ovf_q, ovf_d;

  logic              start_q;
  hw_stacking_mode_t mode_q;
  logic              ack_q;
  logic              take_q;
  logic              mdone_q;
  logic              halt_q;
  logic              tout_q;

  always_comb begin
    state_d = state_q;
    nest_d  = nest_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (mret_i && (nest_q != '0) && irq_req_i) begin
          state_d = TAIL;
        end else if (mret_i && (nest_q != '0)) begin
          state_d = RST_START;
        end else if (mret_i) begin
          state_d = PASS;
        end else if (irq_req_i) begin
          if (nest_q < NEST_MAX) state_d = SAVE_START;
          else                   ovf_d   = 1'b1;
        end
      end
      SAVE_START: begin
        state_d = SAVE_WAIT;
        timer_d = '0;
      end
      RST_START: begin
        state_d = RST_WAIT;
        timer_d = '0;
      end
      // A done seen while the timer is still 0 is the stale registered done
      // of the previous sequence. A qualifying done wins over the timeout in
      // the same cycle; the timer stops counting once it reaches TMAX.
      SAVE_WAIT, RST_WAIT: begin
        if (hws_done_i && (timer_q != '0)) begin
          state_d = (state_q == SAVE_WAIT) ? SAVE_ACK : RST_ACK;
        end else if (timer_q == TMAX) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SAVE_ACK: begin
        nest_d  = nest_q + 1'b1;
        state_d = IDLE;
      end
      RST_ACK: begin
        nest_d  = nest_q - 1'b1;
        state_d = IDLE;
      end
      TAIL:    state_d = IDLE;
      PASS:    state_d = IDLE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered by decoding the next state, so each output is
  // valid in the same cycle as the state it belongs to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      nest_q  <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      start_q <= 1'b0;
      mode_q  <= HWS_SAVE;
      ack_q   <= 1'b0;
      take_q  <= 1'b0;
      mdone_q <= 1'b0;
      halt_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nest_q  <= nest_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      start_q <= (state_d == SAVE_START) || (state_d == RST_START);
      mode_q  <= ((state_d == RST_START) || (state_d == RST_WAIT) ||
                  (state_d == RST_ACK)) ? HWS_RESTORE : HWS_SAVE;
      ack_q   <= (state_d == SAVE_ACK) || (state_d == RST_ACK);
      take_q  <= (state_d == SAVE_ACK) || (state_d == TAIL);
      mdone_q <= (state_d == RST_ACK) || (state_d == PASS);
      halt_q  <= (state_d != IDLE);
      tout_q  <= (state_d == ERROR);
    end
  end

  assign hws_start_o    = start_q;
  assign hws_mode_o     = mode_q;
  assign hws_ack_o      = ack_q;
  assign irq_take_o     = take_q;
  assign mret_done_o    = mdone_q;
  assign fetch_halt_o   = halt_q;
  assign nest_level_o   = nest_q;
  assign err_overflow_o = ovf_q;
  assign err_timeout_o  = tout_q;

endmodule

// File: tb/tb_rt_ibex_hws_ctrl.sv
// Testbench for rt_ibex_hws_ctrl: a table of directed operations, randomized
// operations checked cycle-by-cycle against a transaction-level timeline
// model, plus hand-written timeout and mid-sequence reset sequences.
module tb_rt_ibex_hws_ctrl;
  import rt_ibex_hws_pkg::*;

  localparam int DEPTH = 2;
  localparam int TOUT  = 16;

  localparam int OP_IRQ  = 0;
  localparam int OP_MRET = 1;
  localparam int OP_BOTH = 2;

  localparam int K_SAVE = 0;
  localparam int K_RST  = 1;
  localparam int K_TAIL = 2;
  localparam int K_PASS = 3;
  localparam int K_OVF  = 4;

  logic clk, rst_ni;
  logic irq, mret, done;
  logic start, ack, take, mdone, halt, ovf, tout;
  hw_stacking_mode_t mode;
  logic [$clog2(DEPTH+1)-1:0] nest;

  logic irq2, mret2, done2;
  logic start2, ack2, take2, mdone2, halt2, ovf2, tout2;
  hw_stacking_mode_t mode2;
  logic [2:0] nest2;

  int passed = 0;
  int total  = 0;
  int m_nest = 0;
  bit m_ovf  = 1'b0;

  rt_ibex_hws_ctrl #(.NEST_DEPTH(DEPTH), .TIMEOUT(TOUT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .irq_req_i(irq), .mret_i(mret),
    .hws_start_o(start), .hws_mode_o(mode), .hws_done_i(done),
    .hws_ack_o(ack), .irq_take_o(take), .mret_done_o(mdone),
    .fetch_halt_o(halt), .nest_level_o(nest),
    .err_overflow_o(ovf), .err_timeout_o(tout)
  );

  rt_ibex_hws_ctrl #(.NEST_DEPTH(4), .TIMEOUT(8)) dut_to (
    .clk_i(clk), .rst_ni(rst_ni), .irq_req_i(irq2), .mret_i(mret2),
    .hws_start_o(start2), .hws_mode_o(mode2), .hws_done_i(done2),
    .hws_ack_o(ack2), .irq_take_o(take2), .mret_done_o(mdone2),
    .fetch_halt_o(halt2), .nest_level_o(nest2),
    .err_overflow_o(ovf2), .err_timeout_o(tout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {start, mode==RESTORE, ack, take, mret_done, halt, nest[3:0], ovf, tout}
  function automatic logic [11:0] pk(input logic s, input logic m, input logic a,
                                     input logic t, input logic md, input logic h,
                                     input int n, input logic o, input logic to);
    logic [3:0] n4;
    n4 = 4'(n);
    return {s, m, a, t, md, h, n4, o, to};
  endfunction

  function automatic logic [11:0] vec_main();
    return pk(start, mode == HWS_RESTORE, ack, take, mdone, halt, int'(nest), ovf, tout);
  endfunction

  function automatic logic [11:0] vec_to();
    return pk(start2, mode2 == HWS_RESTORE, ack2, take2, mdone2, halt2, int'(nest2), ovf2, tout2);
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Runs one operation starting in the current (IDLE) cycle, called at a
  // negedge. Cycle 0 is this cycle; expected outputs per later cycle come
  // from the documented latencies: start at 1, ack/take/mret_done at d+2,
  // IDLE with updated nest at d+3 for handshakes; one-cycle TAIL/PASS.
  task automatic do_op(input int op, input int d, input bit stale, input string tag);
    int kind, len, n0, ne;
    bit hs;
    logic [11:0] e;
    n0 = m_nest;
    if (op == OP_IRQ)   kind = (m_nest < DEPTH) ? K_SAVE : K_OVF;
    else if (m_nest == 0) kind = K_PASS;
    else                kind = (op == OP_BOTH) ? K_TAIL : K_RST;
    hs  = (kind == K_SAVE) || (kind == K_RST);
    len = hs ? d + 3 : 2;
    irq  = (op != OP_MRET);
    mret = (op != OP_IRQ);
    if (kind == K_OVF) m_ovf = 1'b1;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      irq  = 1'b0;
      mret = 1'b0;
      done = hs && ((c == d + 1) || (stale && c == 2));
      ne = n0;
      if (hs && c == d + 3) ne = (kind == K_SAVE) ? n0 + 1 : n0 - 1;
      e = pk(hs && c == 1,
             kind == K_RST && c <= d + 2,
             hs && c == d + 2,
             (kind == K_SAVE && c == d + 2) || (kind == K_TAIL && c == 1),
             (kind == K_RST && c == d + 2) || (kind == K_PASS && c == 1),
             hs ? (c <= d + 2) : (kind != K_OVF && c == 1),
             ne, m_ovf, 1'b0);
      chk($sformatf("%s_c%0d", tag, c), vec_main(), e);
    end
    done = 1'b0;
    if (kind == K_SAVE) m_nest++;
    if (kind == K_RST)  m_nest--;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    m_nest = 0;
    m_ovf  = 1'b0;
  endtask

  typedef struct {
    int op;
    int d;
    bit stale;
    int exp_nest;
    bit exp_ovf;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{OP_IRQ,  12, 1'b0, 1, 1'b0};  // save, done 12 after start
    tbl[1] = '{OP_MRET, 12, 1'b0, 0, 1'b0};  // restore
    tbl[2] = '{OP_MRET,  2, 1'b0, 0, 1'b0};  // PASS at nest 0
    tbl[3] = '{OP_BOTH,  2, 1'b0, 0, 1'b0};  // mret wins over irq at nest 0
    tbl[4] = '{OP_IRQ,   6, 1'b1, 1, 1'b0};  // stale done ignored
    tbl[5] = '{OP_BOTH,  2, 1'b0, 1, 1'b0};  // tail-chain
    tbl[6] = '{OP_IRQ,  17, 1'b0, 2, 1'b0};  // done exactly at timer==TIMEOUT
    tbl[7] = '{OP_IRQ,   2, 1'b0, 2, 1'b1};  // overflow at full depth
    tbl[8] = '{OP_MRET,  5, 1'b1, 1, 1'b1};  // overflow stays sticky
    tbl[9] = '{OP_MRET,  3, 1'b0, 0, 1'b1};

    rst_ni = 1'b0;
    irq = 1'b0; mret = 1'b0; done = 1'b0;
    irq2 = 1'b0; mret2 = 1'b0; done2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_main", vec_main(), 12'h000);
    chk("reset_to", vec_to(), 12'h000);
    rst_ni = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].op, tbl[i].d, tbl[i].stale, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_nest", i), 12'(nest), 12'(tbl[i].exp_nest));
      chk($sformatf("tbl%0d_ovf", i), 12'(ovf), 12'(tbl[i].exp_ovf));
    end

    do_reset();
    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, 2)), int'($urandom_range(2, 17)),
            bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // Timeout on the TIMEOUT=8 instance: WAIT entered at cycle 2, ERROR at 11;
    // a late done must not leave ERROR.
    irq2 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      irq2  = 1'b0;
      done2 = (c == 13);
      chk($sformatf("tout_c%0d", c), vec_to(),
          pk(c == 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, c >= 11));
    end
    done2 = 1'b0;

    // Reset in the middle of a save with one frame already stacked.
    do_reset();
    do_op(OP_IRQ, 4, 1'b0, "pre_rst");
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_wait", vec_main(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0));
    rst_ni = 1'b0;
    #1;
    chk("async_rst_main", vec_main(), 12'h000);
    chk("async_rst_to", vec_to(), 12'h000);
    @(negedge clk);
    rst_ni = 1'b1;
    m_nest = 0;
    m_ovf  = 1'b0;
    @(negedge clk);
    chk("post_rst", vec_main(), 12'h000);
    do_op(OP_MRET, 2, 1'b0, "post_rst_pass");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rt_ibex_hws_ctrl.md
# rt_ibex_hws_ctrl

Initiator-side controller for the RT-IBEX hardware stacking unit. It sits between the core's interrupt/`mret` logic and the stacking unit. On interrupt entry it requests a context SAVE, and on `mret` it requests a RESTORE. It sequences the stacker's start/done/ack handshake, halts fetch while a sequence runs, tracks nesting depth, supports tail-chaining, and flags overflow and stacker timeouts.

## Interface
Parameters:
- `NEST_DEPTH`, default 4: maximum number of stacked frames; must be ≥ 1.
- `TIMEOUT`, default 64: maximum cycles in a WAIT state before a fatal timeout; must be ≥ 2.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `irq_req_i`  in  1  enabled interrupt pending; level.
- `mret_i`  in  1  `mret` retiring; single-cycle pulse.
- `hws_start_o`  out  1  start request to the stacker.
- `hws_mode_o`  out  `hw_stacking_mode_t`  SAVE or RESTORE.
- `hws_done_i`  in  1  registered done from the stacker.
- `hws_ack_o`  out  1  acknowledges done.
- `irq_take_o`  out  1  interrupt committed; core redirects to the handler.
- `mret_done_o`  out  1  `mret` context restore complete; core redirects to `mepc`.
- `fetch_halt_o`  out  1  halts IF/ID issue while a sequence runs.
- `nest_level_o`  out  `$clog2(NEST_DEPTH+1)`  current stacked-frame count.
- `err_overflow_o`  out  1  sticky: interrupt refused at full depth.
- `err_timeout_o`  out  1  sticky: stacker did not signal done in time.

## Operation
- Moore FSM. All outputs are decoded from registered state and registered counters.
- States: IDLE, SAVE_START, SAVE_WAIT, SAVE_ACK, RST_START, RST_WAIT, RST_ACK, TAIL, PASS, ERROR.
- IDLE transitions, evaluated in priority order:
  - `mret_i` && nest>0 && `irq_req_i` → TAIL.
  - `mret_i` && nest>0 → RST_START.
  - `mret_i` && nest==0 → PASS.
  - `irq_req_i` && nest<NEST_DEPTH → SAVE_START.
  - `irq_req_i` && nest==NEST_DEPTH → stay in IDLE and set `err_overflow_o`.
- SAVE_START / RST_START: `hws_start_o`=1 for exactly one cycle, then enter the matching WAIT state and clear the timer.
- SAVE_WAIT / RST_WAIT:
  - The timer increments every cycle, saturating at `TIMEOUT`.
  - `hws_done_i` is ignored in the first WAIT cycle (timer==0). This blanks a stale registered done from the previous sequence.
  - `hws_done_i`=1 with timer≥1 → the matching ACK state.
  - Timer==`TIMEOUT` without a qualifying done → ERROR.
- SAVE_ACK: assert `hws_ack_o`=1 and `irq_take_o`=1, nest+1, then go to IDLE.
- RST_ACK: assert `hws_ack_o`=1 and `mret_done_o`=1, nest−1, then go to IDLE.
- TAIL: the stacked frame is reused, so there is no stacker handshake. Assert `irq_take_o`=1 for one cycle, leave nest unchanged, then go to IDLE.
- PASS: `mret` with no stacked frame. Assert `mret_done_o`=1 for one cycle, then go to IDLE.
- ERROR: absorbing state that only reset exits. `err_timeout_o`=1 and `fetch_halt_o`=1 hold for as long as ERROR persists.
- `hws_mode_o`:
  - RESTORE in RST_START, RST_WAIT and RST_ACK.
  - SAVE in all other states.
- `fetch_halt_o`=1 in every state except IDLE.
- Nest counter never wraps. Increment happens only when nest<NEST_DEPTH and decrement only when nest>0; both are guaranteed by the transition guards.
- `err_overflow_o` and `err_timeout_o` set and hold; they clear only on reset.

## Timing
- Reset values:
  - State = IDLE; nest=0; timer=0.
  - `hws_start_o`=0, `hws_ack_o`=0, `irq_take_o`=0, `mret_done_o`=0, `fetch_halt_o`=0, both error flags=0.
  - `hws_mode_o`=SAVE.
- Reset mid-sequence returns to IDLE in the same cycle it is asserted (asynchronous). The stacker shares `rst_ni`, so no handshake is left dangling.
- Save latency: `irq_req_i` sampled in IDLE at cycle 0.
  - Cycle 1: `hws_start_o`.
  - Cycle 2 onward: WAIT.
  - `hws_done_i` first seen at cycle k → `hws_ack_o` and `irq_take_o` at k+1.
  - IDLE at k+2. `irq_req_i` may be sampled again at k+2.
- Restore latency: same shape starting from `mret_i`, with `mret_done_o` at k+1.
- Tail-chain: `mret_i` at cycle 0 → `irq_take_o` at cycle 1 → IDLE at cycle 2. `hws_start_o` never asserts.
- Timeout: the WAIT state is entered at cycle w, so the timer is 0 at w. ERROR is entered at w+TIMEOUT+1.
- `mret_i` arriving outside IDLE is not accepted. The core guarantees no `mret` retires while `fetch_halt_o`=1.

## Test plan
- Save: nest=0, `irq_req_i`=1, stacker asserts done 12 cycles after start → `hws_start_o` high 1 cycle with mode SAVE, `hws_ack_o` and `irq_take_o` high 1 cycle, `nest_level_o`=1, `fetch_halt_o` high from start through ack.
- Restore: nest=1, `mret_i` pulse with no interrupt pending, done after 12 cycles → mode RESTORE, `mret_done_o` high 1 cycle, `nest_level_o`=0.
- Tail-chain and PASS:
  - nest=1, `mret_i` and `irq_req_i` in the same cycle → TAIL, `irq_take_o` high 1 cycle, `hws_start_o` never asserts, nest stays 1.
  - nest=0, `mret_i` → `mret_done_o` high 1 cycle the next cycle.
- Overflow: `NEST_DEPTH`=2, two completed saves (nest=2), then `irq_req_i`=1 → no `hws_start_o`, `err_overflow_o`=1 and sticky, state stays IDLE.
- Timeout: `TIMEOUT`=8, `hws_done_i` held 0 → ERROR at WAIT entry +9, `err_timeout_o`=1, `fetch_halt_o`=1 until reset.
- Stale done and reset:
  - `hws_done_i`=1 in the first WAIT cycle, then 0 → ignored; the controller stays in WAIT.
  - `rst_ni` pulsed low during SAVE_WAIT → all outputs return to reset values immediately and nest=0.
